// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit start validation, centre sampling,
// stop-bit check, valid/ready byte output with framing-error and overrun pulses.
module uart_rx_frame #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     idx_q;
    logic [7:0]     shreg_q;
    logic           rx_meta, rx_s;
    logic           shift_en, frame_done, stop_bad;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        stop_bad   = 1'b0;
        case (state_q)
            S_IDLE:  if (!rx_s) state_d = S_START;
            S_START: if (cnt_q == CNT_HALF_END) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA: begin
                if (cnt_q == CNT_BIT_END) begin
                    shift_en = 1'b1;
                    if (idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_BIT_END) begin
                    if (rx_s) begin
                        frame_done = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = S_BREAK;
                    end
                end
            end
            // A held-low line after a bad stop bit must return high before a new start is armed.
            S_BREAK: if (rx_s) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the shift register is reset with the rest of the datapath so a reset never exposes stale bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shreg_q <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_d != state_q || cnt_q == CNT_BIT_END || state_q == S_IDLE || state_q == S_BREAK)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + CW'(1);
            if (state_q == S_IDLE)
                idx_q <= 3'd0;
            else if (shift_en)
                idx_q <= idx_q + 3'd1;
            if (shift_en)
                shreg_q[idx_q] <= rx_s;
        end
    end

    // A completed frame replaces the held byte only if that byte is consumed on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= frame_done && rx_valid && !rx_ready;
            if (frame_done && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 10 clocks per bit: clean frames, glitch, framing error,
// overrun, same-cycle consume, and mid-frame reset.
module tb_uart_rx_frame;
    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int   acc_count   = 0;
    int   valid_cycles = 0;
    int   ferr_count  = 0;
    int   ovr_count   = 0;
    logic [7:0] last_acc = 8'h00;

    uart_rx_frame #(
        .CLK_FREQ(1_000_000),
        .BAUD    (100_000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Event recorder sampled on the inactive edge.
    always @(negedge clk) begin
        if (rx_valid) valid_cycles++;
        if (rx_valid && rx_ready) begin
            acc_count++;
            last_acc = rx_data;
        end
        if (frame_err) ferr_count++;
        if (overrun) ovr_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller is 1 time unit after a posedge; each bit is held for CPB clocks.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int a0, v0, f0, o0;

    initial begin
        rst_n    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        idle(5);

        // 1: clean frame with consumer ready
        rx_ready = 1'b1;
        a0 = acc_count; v0 = valid_cycles; f0 = ferr_count; o0 = ovr_count;
        send_frame(8'h41, 1'b1);
        idle(5);
        check("t1_accepts", acc_count - a0, 1);
        check("t1_data", last_acc, 8'h41);
        check("t1_valid_cycles", valid_cycles - v0, 1);
        check("t1_ferr", ferr_count - f0, 0);
        check("t1_ovr", ovr_count - o0, 0);

        // 2: 3-cycle glitch is rejected at the start-bit centre
        a0 = acc_count; f0 = ferr_count;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        @(negedge clk);
        check("t2_busy_hi", busy, 1);
        repeat (20) @(posedge clk);
        #1;
        check("t2_busy_lo", busy, 0);
        check("t2_accepts", acc_count - a0, 0);
        check("t2_ferr", ferr_count - f0, 0);

        // 3: bad stop bit, long low hold, then a good frame
        a0 = acc_count; f0 = ferr_count;
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("t3_busy_break", busy, 1);
        check("t3_ferr", ferr_count - f0, 1);
        check("t3_no_accept", acc_count - a0, 0);
        idle(10);
        check("t3_busy_lo", busy, 0);
        send_frame(8'hA5, 1'b1);
        idle(5);
        check("t3_accepts", acc_count - a0, 1);
        check("t3_data", last_acc, 8'hA5);
        check("t3_ferr_total", ferr_count - f0, 1);

        // 4: back-to-back frames with consumer stalled
        rx_ready = 1'b0;
        o0 = ovr_count; f0 = ferr_count;
        send_frame(8'h00, 1'b1);
        check("t4_valid1", rx_valid, 1);
        check("t4_data1", rx_data, 8'h00);
        send_frame(8'hFF, 1'b1);
        check("t4_ovr", ovr_count - o0, 1);
        check("t4_valid2", rx_valid, 1);
        check("t4_data2", rx_data, 8'h00);
        check("t4_no_ferr", ferr_count - f0, 0);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_valid_drop", rx_valid, 0);
        check("t4_acc_data", last_acc, 8'h00);
        rx_ready = 1'b0;
        idle(5);

        // 5: consume on the exact cycle the second frame completes
        o0 = ovr_count; a0 = acc_count;
        send_frame(8'h12, 1'b1);
        fork
            send_frame(8'h34, 1'b1);
            begin
                repeat (97) @(posedge clk);
                #1;
                rx_ready = 1'b1;
                @(posedge clk);
                #1;
                rx_ready = 1'b0;
            end
        join
        check("t5_no_ovr", ovr_count - o0, 0);
        check("t5_valid", rx_valid, 1);
        check("t5_data", rx_data, 8'h34);
        check("t5_acc_data", last_acc, 8'h12);
        check("t5_accepts", acc_count - a0, 1);

        // 6: reset during data bit 4, with 0x34 still pending
        fork
            send_frame(8'h3C, 1'b1);
            begin
                repeat (55) @(posedge clk);
                #1;
                check("t6_busy_pre", busy, 1);
                rst_n = 1'b0;
                #1;
                check("t6_valid", rx_valid, 0);
                check("t6_data", rx_data, 8'h00);
                check("t6_busy", busy, 0);
                check("t6_ferr", frame_err, 0);
                check("t6_ovr", overrun, 0);
            end
        join
        check("t6_hold_valid", rx_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);
        rx_ready = 1'b1;
        a0 = acc_count; f0 = ferr_count;
        send_frame(8'hC3, 1'b1);
        idle(5);
        check("t6_accepts", acc_count - a0, 1);
        check("t6_acc_data", last_acc, 8'hC3);
        check("t6_no_ferr", ferr_count - f0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
